// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and helpers for the bus host arbiter
package bus_arb_pkg;

    // ARB : pick a winner each cycle; HOLD : keep the stalled winner until granted
    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Width of a host index; never zero so single-bit buses stay legal
    function automatic int host_idx_width(input int nr_hosts);
        return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
    endfunction

endpackage

// File: rtl/bus_id_fifo.sv
// rtl/bus_id_fifo.sv - in-order FIFO of host IDs for outstanding transactions
//
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   push_i        write wdata_i (accepted when not full, or when popping)
//   pop_i         drop the head entry (ignored when empty)
//   wdata_i       ID to store
//   rdata_o       head entry, valid when not empty
//   empty_o       no entries
//   full_o        Depth entries
//   count_o       number of entries
module bus_id_fifo #(
    parameter int Depth = 2,
    parameter int Width = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           wdata_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so wrap explicitly
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal alongside a pop; the head is
    // read combinationally before the slot is overwritten at the edge.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// rtl/bus_host_arbiter.sv - round-robin arbiter sharing one device port among bus hosts
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   host_req_i/gnt_o    per-host request / grant (grant one-hot or zero)
//   host_addr_i, host_we_i, host_be_i, host_wdata_i  per-host request payload (flat)
//   host_rvalid_o       per-host response valid (one-hot or zero)
//   host_rdata_o/err_o  response data/error shared by all hosts
//   dev_*               device-side request/response port
//   unexp_rsp_o         sticky: response arrived with nothing outstanding
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic                              host_err_o,
    output logic                              dev_req_o,
    input  logic                              dev_gnt_i,
    output logic [AddressWidth-1:0]           dev_addr_o,
    output logic                              dev_we_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    input  logic                              dev_rvalid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i,
    output logic                              unexp_rsp_o
);

    localparam int BeW  = DataWidth / 8;
    localparam int IdxW = host_idx_width(NrHosts);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    arb_state_e       state_q;
    logic [IdxW-1:0]  ptr_q, hold_idx_q;
    logic             unexp_q;

    logic [IdxW-1:0]  win_idx, sel_idx, head_idx;
    logic             win_found, sel_valid, can_issue, grant, pop;
    logic             fifo_empty, fifo_full;
    logic [CntW-1:0]  fifo_count;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (i == IdxW'(NrHosts - 1)) ? '0 : i + IdxW'(1);
    endfunction

    // Scan from the pointer upward so the last-granted host ranks lowest
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int i = 0; i < NrHosts; i++) begin
            if (!win_found && host_req_i[(int'(ptr_q) + i) % NrHosts]) begin
                win_found = 1'b1;
                win_idx   = IdxW'((int'(ptr_q) + i) % NrHosts);
            end
        end
    end

    // A response in this cycle frees a slot, so it counts as credit
    assign can_issue = (fifo_count < CntW'(MaxOutstanding)) | dev_rvalid_i;

    assign sel_idx   = (state_q == HOLD) ? hold_idx_q : win_idx;
    assign sel_valid = (state_q == HOLD) ? host_req_i[hold_idx_q] : win_found;
    assign dev_req_o = ~rst_i & sel_valid & can_issue;
    assign grant     = dev_req_o & dev_gnt_i;
    assign pop       = ~rst_i & dev_rvalid_i & ~fifo_empty;

    always_comb begin
        dev_addr_o  = host_addr_i[AddressWidth-1:0];
        dev_we_o    = host_we_i[0];
        dev_be_o    = host_be_i[BeW-1:0];
        dev_wdata_o = host_wdata_i[DataWidth-1:0];
        for (int i = 0; i < NrHosts; i++) begin
            if (sel_idx == IdxW'(i)) begin
                dev_addr_o  = host_addr_i[i*AddressWidth +: AddressWidth];
                dev_we_o    = host_we_i[i];
                dev_be_o    = host_be_i[i*BeW +: BeW];
                dev_wdata_o = host_wdata_i[i*DataWidth +: DataWidth];
            end
        end
    end

    assign host_gnt_o    = grant ? (NrHosts'(1) << sel_idx) : '0;
    assign host_rvalid_o = pop ? (NrHosts'(1) << head_idx) : '0;
    assign host_rdata_o  = dev_rdata_i;
    assign host_err_o    = dev_err_i;
    assign unexp_rsp_o   = unexp_q;

    bus_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .pop_i   (pop),
        .wdata_i (sel_idx),
        .rdata_o (head_idx),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            hold_idx_q <= '0;
            unexp_q    <= 1'b0;
        end else begin
            if (dev_rvalid_i && fifo_empty) begin
                unexp_q <= 1'b1;
            end
            if (grant) begin
                ptr_q <= next_idx(sel_idx);
            end
            case (state_q)
                ARB: begin
                    if (dev_req_o && !dev_gnt_i) begin
                        hold_idx_q <= win_idx;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    // Granted, or the host withdrew: either way re-arbitrate
                    if (grant || !host_req_i[hold_idx_q]) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
- Shares one device-side request port between NrHosts bus hosts, for example the core data port plus a DMA or debug host, ahead of the address-decoding bus.
- Uses round-robin arbitration with a request hold: a host stays selected until the device grants it.
- Tracks outstanding transactions in an in-order ID FIFO, so each device response is routed back to the host that issued it.
- Uses the same req/gnt/rvalid protocol on both sides. Responses come back in order, with exactly one rvalid per granted request, at least one cycle after the grant.

Parameters:
- NrHosts, 2, number of requesting hosts (≥2).
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.
- MaxOutstanding, 2, maximum granted-but-unanswered transactions (≥1); also the depth of the ID FIFO.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- host_req_i  in  NrHosts  per-host request.
- host_gnt_o  out  NrHosts  per-host grant, one-hot or zero.
- host_addr_i  in  NrHosts×AddressWidth  per-host address.
- host_we_i  in  NrHosts  per-host write enable.
- host_be_i  in  NrHosts×DataWidth/8  per-host byte enables.
- host_wdata_i  in  NrHosts×DataWidth  per-host write data.
- host_rvalid_o  out  NrHosts  per-host response valid, one-hot or zero.
- host_rdata_o  out  DataWidth  response data, common to all hosts, qualified by host_rvalid_o.
- host_err_o  out  1  response error, common to all hosts, qualified by host_rvalid_o.
- dev_req_o  out  1  device request.
- dev_gnt_i  in  1  device grant.
- dev_addr_o  out  AddressWidth  device address.
- dev_we_o  out  1  device write enable.
- dev_be_o  out  DataWidth/8  device byte enables.
- dev_wdata_o  out  DataWidth  device write data.
- dev_rvalid_i  in  1  device response valid.
- dev_rdata_i  in  DataWidth  device response data.
- dev_err_i  in  1  device response error.
- unexp_rsp_o  out  1  sticky flag: an rvalid arrived with the ID FIFO empty.

Behaviour:

Reset:
- Asynchronous on rst_i high; all registered state cleared.
- While rst_i is high: dev_req_o=0, host_gnt_o=0, host_rvalid_o=0, unexp_rsp_o=0.
- Round-robin pointer = 0, FIFO empty, FSM in ARB.
- An in-flight transaction is abandoned on reset; a late dev_rvalid_i after reset sets unexp_rsp_o.

Credit:
- can_issue = (count < MaxOutstanding) | dev_rvalid_i.
- A pop in the same cycle frees a slot, so a full FIFO with a response arriving still accepts a new grant.

FSM states:
- ARB:
  - Winner = first host with host_req_i set, scanning from the pointer upward and wrapping modulo NrHosts.
  - If a winner exists and can_issue: dev_req_o=1 and the winner's addr/we/be/wdata are driven combinationally.
  - If dev_gnt_i in the same cycle: host_gnt_o[winner]=1, push the winner ID, pointer = winner+1 mod NrHosts, stay in ARB.
  - If no dev_gnt_i: latch the winner ID and go to HOLD.
  - If no request or no credit: dev_req_o=0.
- HOLD:
  - The latched host is driven unconditionally; other requests are ignored.
  - dev_req_o = host_req_i[latched] & can_issue.
  - On dev_gnt_i: host_gnt_o[latched]=1, push the ID, update the pointer, return to ARB.
  - If the latched host drops its request (protocol violation): dev_req_o=0, return to ARB without a pointer update.

Grant path:
- host_gnt_o is combinational from dev_gnt_i; zero added latency on the request path.

Response path:
- dev_rvalid_i pops the FIFO head.
- In the same cycle: host_rvalid_o[head]=1 and host_rdata_o/host_err_o = dev_rdata_i/dev_err_i. Zero latency, combinational.
- host_rdata_o is muxed through unconditionally and is only meaningful with rvalid.
- dev_rvalid_i with the FIFO empty: no host_rvalid_o; unexp_rsp_o set until reset.

FIFO:
- Push and pop in the same cycle: count unchanged, order preserved.
- When full, a push occurs only together with a pop (guaranteed by can_issue).
- Pointers wrap modulo MaxOutstanding; MaxOutstanding need not be a power of two.

Round-robin:
- A host that received a grant has lowest priority at the next arbitration.
- A host holding its request continuously is granted within NrHosts grants.

Decomposition:
- Package bus_arb_pkg:
  - arb_state_e {ARB, HOLD}.
  - Function host_idx_width(NrHosts) returning max(1, $clog2(NrHosts)).
- Sub-module bus_id_fifo:
  - Parameters Depth and Width.
  - Ports push/pop/wdata/rdata/empty/full/count.
  - Clocked by clk_i, asynchronous active-high rst_i.
- The arbiter contains the FSM, the round-robin pointer, and the output muxes.

Test Plan:
- Single host, device with dev_gnt_i=1 and rvalid one cycle later:
  - Stimulus: host 0 writes addr 0x100010, data 0xDEADBEEF, be 0xF.
  - Response: dev_* mirrors host 0 in the request cycle, host_gnt_o=01, next cycle host_rvalid_o=01, host_err_o=0.
- Both hosts requesting continuously, device always grants, MaxOutstanding=2:
  - Response: grants alternate 01,10,01,10 starting with host 0 after reset.
  - Each rvalid goes to the host granted two transactions earlier in order.
- Device stalls with dev_gnt_i=0 for 3 cycles while host 0 is selected and host 1 raises its request:
  - Response: dev_addr_o stays at host 0's address for all 3 cycles, FSM in HOLD.
  - Response: host 0 is granted on the 4th cycle; host 1 is granted next.
- Credit limit, MaxOutstanding=2:
  - Stimulus: two grants issued, responses delayed 5 cycles.
  - Response: dev_req_o=0 until the first rvalid; a third grant is allowed in the same cycle as that rvalid.
  - Response: count stays at 2 and order is preserved.
- Unexpected response:
  - Stimulus: dev_rvalid_i=1 with the FIFO empty.
  - Response: host_rvalid_o=00, unexp_rsp_o=1 and stays set; cleared only by rst_i.
- Reset mid-operation:
  - Stimulus: assert rst_i asynchronously with one transaction outstanding.
  - Response: outputs go to 0 immediately, the pointer returns to 0, and the first post-reset grant goes to host 0 when both hosts request.
